// File: rtl/s_mem_arbiter.sv
// Round-robin owner of the single-port RC4 S memory: one requester at a time drives the
// registered mem_* pins, and read data returns tagged to the requester that issued it.

module s_mem_arb_lane (
    input  logic       gnt,
    input  logic       acc_valid,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       wren,
    output logic       hit,
    output logic [7:0] addr_m,
    output logic [7:0] wdata_m,
    output logic       wren_m
);
    // Non-owners contribute zeros, so the owner's access can be OR-reduced across lanes.
    assign hit     = gnt & acc_valid;
    assign addr_m  = hit ? addr  : '0;
    assign wdata_m = hit ? wdata : '0;
    assign wren_m  = hit & wren;
endmodule

module s_mem_arbiter #(
    parameter int N_REQ  = 3,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    output logic [N_REQ-1:0]   gnt,
    input  logic [N_REQ-1:0]   acc_valid,
    input  logic [8*N_REQ-1:0] acc_addr,
    input  logic [8*N_REQ-1:0] acc_wdata,
    input  logic [N_REQ-1:0]   acc_wren,
    output logic [7:0]         rdata,
    output logic [N_REQ-1:0]   rvalid,
    output logic [7:0]         mem_addr,
    output logic [7:0]         mem_wdata,
    output logic               mem_wren,
    input  logic [7:0]         mem_q,
    output logic               busy
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(RD_LAT + 2);

    typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

    state_t                      state, state_n;
    logic [N_REQ-1:0]            gnt_n;
    logic [IDX_W-1:0]            ptr, ptr_n, own, own_n, pick;
    logic [CNT_W-1:0]            rd_cnt, rd_cnt_n;
    logic [N_REQ-1:0]            hit, lane_wren;
    logic [N_REQ-1:0][7:0]       lane_addr, lane_wdata;
    logic [7:0]                  sel_addr, sel_wdata;
    logic                        sel_wren, accept, rd_acc;
    logic [RD_LAT:0]             vld_pipe;
    logic [IDX_W-1:0]            tag_pipe [RD_LAT:0];

    s_mem_arb_lane u_lane [N_REQ-1:0] (
        .gnt       (gnt),
        .acc_valid (acc_valid),
        .addr      (acc_addr),
        .wdata     (acc_wdata),
        .wren      (acc_wren),
        .hit       (hit),
        .addr_m    (lane_addr),
        .wdata_m   (lane_wdata),
        .wren_m    (lane_wren)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_addr  = sel_addr  | lane_addr[i];
            sel_wdata = sel_wdata | lane_wdata[i];
        end
    end

    assign sel_wren = |lane_wren;
    assign accept   = |hit;
    assign rd_acc   = accept & ~sel_wren;
    assign rd_cnt_n = rd_cnt + CNT_W'(rd_acc) - CNT_W'(|rvalid);
    assign busy     = (state != IDLE);

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        int  j;
        logic found;
        j     = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        ptr_n   = ptr;
        own_n   = own;
        case (state)
            IDLE: if (|req) begin
                gnt_n       = '0;
                gnt_n[pick] = 1'b1;
                own_n       = pick;
                state_n     = OWN;
            end
            OWN: if (!req[own]) begin
                gnt_n   = '0;
                ptr_n   = (own == IDX_W'(N_REQ - 1)) ? '0 : own + IDX_W'(1);
                state_n = (rd_cnt_n != '0) ? DRAIN : IDLE;
            end
            DRAIN: if (rd_cnt == '0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            gnt       <= '0;
            ptr       <= '0;
            own       <= '0;
            rd_cnt    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
            rdata     <= '0;
            rvalid    <= '0;
            vld_pipe  <= '0;
            for (int k = 0; k <= RD_LAT; k++) tag_pipe[k] <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            ptr      <= ptr_n;
            own      <= own_n;
            rd_cnt   <= rd_cnt_n;
            mem_wren <= sel_wren;
            if (accept) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            // Tag travels alongside the read until mem_q for it is valid.
            vld_pipe    <= {vld_pipe[RD_LAT-1:0], rd_acc};
            tag_pipe[0] <= own;
            for (int k = 1; k <= RD_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
            rvalid <= '0;
            if (vld_pipe[RD_LAT]) begin
                rvalid[tag_pipe[RD_LAT]] <= 1'b1;
                rdata                    <= mem_q;
            end
        end
    end
endmodule

// File: tb/tb_s_mem_arbiter.sv
// Directed plus randomized checks of s_mem_arbiter against a transaction-level model:
// round-robin ownership, program-order memory contents, and reads returning 2+RD_LAT later.
module tb_s_mem_arbiter;
    localparam int N = 3;
    localparam int RD_LAT = 1;

    typedef struct {
        int         due;
        int         tag;
        logic [7:0] data;
    } rd_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req, gnt, acc_valid, acc_wren, rvalid;
    logic [8*N-1:0] acc_addr, acc_wdata;
    logic [7:0]    rdata, mem_addr, mem_wdata, mem_q;
    logic          mem_wren, busy;

    logic [7:0] S [256];
    logic [7:0] ref_s [256];
    rd_t        q[$];
    int         errors = 0, checks = 0, cyc = 0, last_pend = 0;
    int         m_ptr = 0, m_owner = -1, n = 0, bad = 0;
    logic [N-1:0] m_gnt = '0;
    logic [2:0] rmask;
    logic       exp_wren = 1'b0;
    logic [7:0] exp_addr = '0, exp_data = '0;

    s_mem_arbiter #(.N_REQ(N), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt), .acc_valid(acc_valid),
        .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_wren(acc_wren),
        .rdata(rdata), .rvalid(rvalid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wren(mem_wren), .mem_q(mem_q), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port synchronous S memory, one clock read latency.
    always @(posedge clk) begin
        if (mem_wren) S[mem_addr] <= mem_wdata;
        mem_q <= S[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("mem_wren", 32'(mem_wren), 32'(exp_wren));
        if (exp_wren) begin
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(exp_data));
        end
        last_pend = q.size();
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rvalid", 32'(rvalid), 32'(1) << q[0].tag);
            chk("rdata", 32'(rdata), 32'(q[0].data));
            void'(q.pop_front());
        end else begin
            chk("rvalid_idle", 32'(rvalid), 32'(0));
        end
        exp_wren  = 1'b0;
        acc_valid = '0;
        acc_wren  = '0;
    endtask

    // Drive one access from requester 'who'; only the current owner's access affects the model.
    task automatic access(input int who, input logic wr, input logic [7:0] a, input logic [7:0] d);
        acc_valid[who]        = 1'b1;
        acc_wren[who]         = wr;
        acc_addr[8*who +: 8]  = a;
        acc_wdata[8*who +: 8] = d;
        if (who == m_owner) begin
            if (wr) begin
                ref_s[a] = d;
                exp_wren = 1'b1;
                exp_addr = a;
                exp_data = d;
            end else begin
                q.push_back('{cyc + 2 + RD_LAT, who, ref_s[a]});
            end
        end
    endtask

    task automatic noise();
        for (int j = 0; j < N; j++)
            if (j != m_owner && $urandom_range(0, 1) == 1)
                access(j, 1'b1, 8'($urandom_range(0, 15)), 8'($urandom));
    endtask

    task automatic grant(input logic [2:0] mask);
        int w;
        w   = -1;
        req = mask;
        for (int k = 0; k < N; k++)
            if (w < 0 && mask[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        m_gnt   = 3'(1 << w);
        m_owner = w;
        step();
        chk("busy_own", 32'(busy), 32'(1));
    endtask

    task automatic release_own(input logic [2:0] keep);
        req     = keep;
        m_gnt   = '0;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        step();
        chk("busy_drop", 32'(busy), 32'(last_pend > 0));
        for (int k = 0; k < 20 && busy === 1'b1; k++) step();
        chk("drain_done", 32'(busy), 32'(0));
        chk("drain_q", 32'(q.size()), 32'(0));
    endtask

    initial begin
        reset = 1'b0; req = '0; acc_valid = '0; acc_wren = '0; acc_addr = '0; acc_wdata = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_rvalid", 32'(rvalid), 32'(0));
        chk("rst_rdata", 32'(rdata), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
        chk("rst_mem_wren", 32'(mem_wren), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        #2 reset = 1'b1;
        step();

        // Contention: 1 wins from pointer 0, then 2 after one IDLE cycle.
        grant(3'b110);
        release_own(3'b100);
        grant(3'b100);
        release_own(3'b000);

        // Fill S[k]=k.
        grant(3'b001);
        for (int k = 0; k < 256; k++) begin
            access(0, 1'b1, 8'(k), 8'(k));
            step();
        end
        release_own(3'b000);
        bad = 0;
        for (int k = 0; k < 256; k++) if (S[k] !== 8'(k)) bad++;
        chk("s_fill", 32'(bad), 32'(0));

        // Back-to-back reads by owner 1, then a read issued with req falling.
        grant(3'b010);
        access(1, 1'b1, 8'h05, 8'h33); step();
        access(1, 1'b1, 8'h09, 8'h7A); step();
        access(1, 1'b0, 8'h05, 8'h00); step();
        access(1, 1'b0, 8'h09, 8'h00); step();
        step(); step(); step();
        access(1, 1'b0, 8'h09, 8'h00);
        release_own(3'b001);

        // Non-owner write attempt while 0 owns.
        grant(3'b001);
        access(2, 1'b1, 8'h10, 8'hEE); step();
        access(0, 1'b0, 8'h10, 8'h00); step();
        step(); step();
        release_own(3'b000);
        chk("s_10", 32'(S[8'h10]), 32'h10);

        // Randomized sessions.
        for (int s = 0; s < 25; s++) begin
            rmask = 3'($urandom_range(1, 7));
            grant(rmask);
            n = $urandom_range(2, 10);
            for (int k = 0; k < n; k++) begin
                noise();
                if ($urandom_range(0, 3) != 0)
                    access(m_owner, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
                if (k == n - 1) release_own(3'b000);
                else step();
            end
        end

        // Reset mid-OWN with a read in flight; pointer is 1 when reset hits.
        grant(3'b001);
        release_own(3'b000);
        grant(3'b010);
        access(1, 1'b0, 8'h05, 8'h00);
        step();
        #2 reset = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'(0));
        chk("arst_rvalid", 32'(rvalid), 32'(0));
        chk("arst_rdata", 32'(rdata), 32'(0));
        chk("arst_mem_addr", 32'(mem_addr), 32'(0));
        chk("arst_mem_wdata", 32'(mem_wdata), 32'(0));
        chk("arst_mem_wren", 32'(mem_wren), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        q.delete();
        req = '0; m_gnt = '0; m_ptr = 0; m_owner = -1; exp_wren = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        step(); step(); step(); step();
        grant(3'b111);
        release_own(3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end
endmodule
